// File: rtl/alu_serial_opq.sv
// Bit-serial Y86 OPq execution unit (addq/subq/andq/xorq).
// One result bit per clock, LSB first, built on the add_1bit full adder.
// The WIDTH-bit result and ZF/SF/OF are committed together on the last bit.

// Single-bit full adder used as the per-bit arithmetic core.
module add_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module alu_serial_opq #(
  parameter int WIDTH = 64,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] val_e,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_zacc;
  // Only WIDTH-1 bits are needed: the final bit arrives combinationally at commit.
  logic [WIDTH-2:0] r_res;

  logic [WIDTH-1:0] r_val_e;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_a_eff;
  logic             w_sum;
  logic             w_cout;
  logic             w_res_bit;
  logic             w_of;
  logic [WIDTH-1:0] w_res_full;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_a_bit    = r_a[0];
  assign w_b_bit    = r_b[0];
  // Subtraction is b + ~a + 1; the +1 comes from the carry preset on accept.
  assign w_a_eff    = w_a_bit ^ (r_op == 2'b01);
  assign w_res_full = {w_res_bit, r_res};

  add_1bit u_add (
    .i_a    (w_b_bit),
    .i_b    (w_a_eff),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: RUN for WIDTH bits, one DONE cycle, DONE may re-accept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
        else       w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next_state = S_DONE;
        else        w_next_state = S_RUN;
      end
      S_DONE: begin
        if (start) w_next_state = S_RUN;
        else       w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Select the current result bit according to the latched function.
  always_comb begin
    w_res_bit = 1'b0;
    case (r_op)
      2'b00:   w_res_bit = w_sum;
      2'b01:   w_res_bit = w_sum;
      2'b10:   w_res_bit = w_b_bit & w_a_bit;
      2'b11:   w_res_bit = w_b_bit ^ w_a_bit;
      default: w_res_bit = 1'b0;
    endcase
  end

  // Signed overflow, meaningful only while the sign bit is being processed.
  always_comb begin
    w_of = 1'b0;
    case (r_op)
      2'b00:   w_of = (w_a_bit == w_b_bit) && (w_res_bit != w_b_bit);
      2'b01:   w_of = (w_a_bit != w_b_bit) && (w_res_bit != w_b_bit);
      default: w_of = 1'b0;
    endcase
  end

  // Operand/result shift registers, bit counter, carry and zero accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_op    <= 2'b00;
      r_cnt   <= {CW{1'b0}};
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_res   <= {(WIDTH-1){1'b0}};
    end else if (w_accept) begin
      r_a     <= val_a;
      r_b     <= val_b;
      r_op    <= op;
      r_cnt   <= {CW{1'b0}};
      r_carry <= (op == 2'b01);
      r_zacc  <= 1'b0;
      r_res   <= {(WIDTH-1){1'b0}};
    end else if (r_state == S_RUN) begin
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_cnt  <= r_cnt + CW'(1);
      r_res  <= w_res_full[WIDTH-1:1];
      r_zacc <= r_zacc | w_res_bit;
      if (!r_op[1]) r_carry <= w_cout;
      else          r_carry <= r_carry;
    end
  end

  // Commit result and flags on the edge that processes the sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val_e <= {WIDTH{1'b0}};
      r_zf    <= 1'b0;
      r_sf    <= 1'b0;
      r_of    <= 1'b0;
    end else if (w_last) begin
      r_val_e <= w_res_full;
      r_zf    <= ~(r_zacc | w_res_bit);
      r_sf    <= w_res_bit;
      r_of    <= w_of;
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_RUN);
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign val_e = r_val_e;
  assign zf    = r_zf;
  assign sf    = r_sf;
  assign of    = r_of;

endmodule

// File: tb/tb_alu_serial_opq.sv
// Directed self-checking bench for alu_serial_opq (WIDTH=64).
module tb_alu_serial_opq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        busy;
  logic        done;
  logic [63:0] val_e;
  logic        zf;
  logic        sf;
  logic        of;

  int nvec  = 0;
  int nfail = 0;

  alu_serial_opq #(.WIDTH(64), .CW(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .val_a (val_a),
    .val_b (val_b),
    .busy  (busy),
    .done  (done),
    .val_e (val_e),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start pulse; returns at the negedge of cycle 1 of RUN.
  task automatic start_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op = o; val_a = a; val_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    val_a = 64'hA5A5_A5A5_A5A5_A5A5;
    val_b = 64'h5A5A_5A5A_5A5A_5A5A;
    op    = 2'b11;
  endtask

  // Wait (bounded) for done; cyc counts cycles since accept, starting at c0.
  task automatic wait_done(input int c0, output int cyc, output int nbusy);
    bit seen;
    seen  = 1'b0;
    cyc   = c0;
    nbusy = 0;
    while (!seen && cyc < 200) begin
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; val_a = 64'd0; val_b = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({busy, done, zf, sf, of} !== 5'b00000) begin
      nfail++;
      $display("FAIL reset_ctl: got busy/done/zf/sf/of=%b expected 00000", {busy, done, zf, sf, of});
    end
    nvec++;
    if (val_e !== 64'd0) begin
      nfail++;
      $display("FAIL reset_val_e: got %h expected 0", val_e);
    end
  endtask

  task automatic test_add();
    int cyc, nb;
    start_op(2'b00, 64'd5, 64'd3);
    wait_done(1, cyc, nb);
    nvec++;
    if (cyc !== 65) begin
      nfail++;
      $display("FAIL add_latency: got %0d expected 65", cyc);
    end
    nvec++;
    if (nb !== 64) begin
      nfail++;
      $display("FAIL add_busy_cycles: got %0d expected 64", nb);
    end
    nvec++;
    if (val_e !== 64'd8 || {zf, sf, of} !== 3'b000) begin
      nfail++;
      $display("FAIL add_result: got %h zso=%b expected 8 zso=000", val_e, {zf, sf, of});
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL add_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_sub();
    int cyc, nb;
    start_op(2'b01, 64'd5, 64'd3);
    wait_done(1, cyc, nb);
    nvec++;
    if (val_e !== 64'hFFFF_FFFF_FFFF_FFFE || {zf, sf, of} !== 3'b010) begin
      nfail++;
      $display("FAIL sub_neg: got %h zso=%b expected fffffffffffffffe zso=010", val_e, {zf, sf, of});
    end
    start_op(2'b01, 64'h8000_0000_0000_0000, 64'd0);
    wait_done(1, cyc, nb);
    nvec++;
    if (val_e !== 64'h8000_0000_0000_0000 || {zf, sf, of} !== 3'b011) begin
      nfail++;
      $display("FAIL sub_ovf: got %h zso=%b expected 8000000000000000 zso=011", val_e, {zf, sf, of});
    end
  endtask

  task automatic test_add_overflow();
    int cyc, nb;
    start_op(2'b00, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    wait_done(1, cyc, nb);
    nvec++;
    if (val_e !== 64'h8000_0000_0000_0000 || {zf, sf, of} !== 3'b011) begin
      nfail++;
      $display("FAIL add_ovf: got %h zso=%b expected 8000000000000000 zso=011", val_e, {zf, sf, of});
    end
  endtask

  task automatic test_logic();
    int cyc, nb;
    start_op(2'b11, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    wait_done(1, cyc, nb);
    nvec++;
    if (val_e !== 64'd0 || {zf, sf, of} !== 3'b100) begin
      nfail++;
      $display("FAIL xor_zero: got %h zso=%b expected 0 zso=100", val_e, {zf, sf, of});
    end
    start_op(2'b10, 64'hF0F0, 64'hFF00);
    wait_done(1, cyc, nb);
    nvec++;
    if (val_e !== 64'hF000 || {zf, sf, of} !== 3'b000) begin
      nfail++;
      $display("FAIL and_mask: got %h zso=%b expected f000 zso=000", val_e, {zf, sf, of});
    end
  endtask

  task automatic test_start_ignored();
    int cyc, nb;
    start_op(2'b00, 64'd10, 64'd20);
    repeat (9) @(negedge clk);
    op = 2'b01; val_a = 64'd100; val_b = 64'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, cyc, nb);
    nvec++;
    if (cyc !== 65) begin
      nfail++;
      $display("FAIL ignore_latency: got %0d expected 65", cyc);
    end
    nvec++;
    if (val_e !== 64'd30) begin
      nfail++;
      $display("FAIL ignore_result: got %0d expected 30", val_e);
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (val_e !== 64'd30 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL hold_idle: got val_e=%0d busy=%b expected 30 0", val_e, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    @(negedge clk);
    op = 2'b00; val_a = 64'd1; val_b = 64'd1; start = 1'b1;
    @(negedge clk);
    op = 2'b01; val_a = 64'd7; val_b = 64'd3;
    wait_done(1, cyc, nb);
    nvec++;
    if (cyc !== 65 || val_e !== 64'd2) begin
      nfail++;
      $display("FAIL b2b_first: got cyc=%0d val_e=%h expected 65 2", cyc, val_e);
    end
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0 || val_e !== 64'd2) begin
      nfail++;
      $display("FAIL b2b_restart: got busy=%b done=%b val_e=%h expected 1 0 2", busy, done, val_e);
    end
    wait_done(1, cyc, nb);
    nvec++;
    if (cyc !== 65) begin
      nfail++;
      $display("FAIL b2b_spacing: got %0d expected 65", cyc);
    end
    nvec++;
    if (val_e !== 64'hFFFF_FFFF_FFFF_FFFC || {zf, sf, of} !== 3'b010) begin
      nfail++;
      $display("FAIL b2b_second: got %h zso=%b expected fffffffffffffffc zso=010", val_e, {zf, sf, of});
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nb, ndone;
    start_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({busy, done, zf, sf, of} !== 5'b00000 || val_e !== 64'd0) begin
      nfail++;
      $display("FAIL rst_mid_clear: got bdzso=%b val_e=%h expected 00000 0", {busy, done, zf, sf, of}, val_e);
    end
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    nvec++;
    if (ndone !== 0) begin
      nfail++;
      $display("FAIL rst_mid_nodone: got %0d active cycles expected 0", ndone);
    end
    start_op(2'b00, 64'd2, 64'd2);
    wait_done(1, cyc, nb);
    nvec++;
    if (cyc !== 65 || val_e !== 64'd4 || {zf, sf, of} !== 3'b000) begin
      nfail++;
      $display("FAIL rst_mid_after: got cyc=%0d val_e=%h zso=%b expected 65 4 000", cyc, val_e, {zf, sf, of});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add_overflow();
    test_logic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/alu_serial_opq.md
Name: alu_serial_opq

Overview:
- Bit-serial Y86 OPq execution unit; sits directly downstream of add_1bit, which it uses as its per-bit arithmetic core.
- Processes one bit per clock, LSB first, for addq/subq/andq/xorq, then presents the WIDTH-bit result plus ZF/SF/OF.
- Used by the sequential execute stage wherever a low-area ALU is preferred over the parallel ripple adder.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 2 and up.
- CW, 7, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request; accepted when state is IDLE or DONE.
- op  input  2  ifun: 00 add (valB+valA), 01 sub (valB-valA), 10 and, 11 xor.
- val_a  input  WIDTH  operand A; sampled only on accepted start.
- val_b  input  WIDTH  operand B; sampled only on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result and flags become valid.
- val_e  output  WIDTH  result; held until next accepted start.
- zf  output  1  zero flag; held with val_e.
- sf  output  1  sign flag; held with val_e.
- of  output  1  signed overflow flag; held with val_e.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, val_e=0, zf=0, sf=0, of=0; carry, counter and shift registers cleared. Reset overrides start in the same cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 goes to RUN. No start stays in IDLE.
  - RUN: counter increments each edge. On the edge where bit WIDTH-1 is processed, go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE. start=1 in DONE is accepted and goes directly to RUN.
- Accept (at edge k):
  - Latch val_a, val_b and op into internal shift registers.
  - Clear counter and the zero accumulator.
  - Carry flop = 1 for sub, 0 otherwise.
  - val_e and the flags keep their previous values until DONE.
- Per bit (edge k+1+i, i=0..WIDTH-1):
  - Bit i of the result comes from the LSBs of the operand shift registers.
  - add: add_1bit(b_i, a_i, c).
  - sub: add_1bit(b_i, ~a_i, c).
  - and: b_i & a_i. xor: b_i ^ a_i.
  - Carry flop takes add_1bit's carry (arithmetic ops only).
  - Result bit shifts in at the MSB of the result shift register; operands shift right by one.
- Latency: done is high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after start is sampled.
- Commit: val_e and flags update on edge k+WIDTH, together with entry to DONE.
  - zf = result==0.
  - sf = result[WIDTH-1].
  - of, add: a and b same sign and result sign differs.
  - of, sub: a and b differ in sign and result sign differs from b.
  - of, and/xor: 0.
- Unsigned carry-out is not reported; Y86 has no CF.
- start while in RUN is ignored. Operands and op are not resampled mid-operation.
- Reset mid-RUN aborts the operation: no done pulse; outputs are cleared as in the Reset rule.
- Back-to-back operations: holding start high through DONE gives one operation every WIDTH+1 cycles.
- The operand ports may change freely after the accept edge.

Test Plan:
- Add: rst 2 cycles; op=00, val_a=5, val_b=3, start 1 cycle -> busy=1 for 64 cycles; done pulses once at cycle 65; val_e=8, zf=0, sf=0, of=0.
- Sub: op=01, val_a=5, val_b=3 -> val_e=0xFFFFFFFFFFFFFFFE, sf=1, zf=0, of=0. Then val_a=0x8000000000000000, val_b=0 -> val_e=0x8000000000000000, of=1, sf=1.
- Add overflow: op=00, val_a=1, val_b=0x7FFFFFFFFFFFFFFF -> val_e=0x8000000000000000, of=1, sf=1, zf=0.
- Logic ops: op=11, val_a=val_b=0xDEADBEEF -> val_e=0, zf=1, of=0. op=10, val_a=0xF0F0, val_b=0xFF00 -> val_e=0xF000, zf=0.
- Handshake: re-pulse start with new operands at cycle 10 of RUN -> ignored; first result unchanged. Holding start high through DONE -> second op begins immediately; done pulses exactly 65 cycles apart.
- Reset mid-op: assert rst at cycle 30 of RUN -> next cycle busy=0, val_e=0, all flags 0, no done pulse. A new add 2+2 afterwards -> val_e=4.
